mem_responder: RTL
==================

# mem_responder

Memory-side responder for the 128-bit beat protocol the TLB-miss refill unit drives. It accepts single-beat read requests (ren_mem/raddr_mem) and returns rvalid_mem/rdata_mem after a fixed latency. It also accepts single-beat masked writes and acknowledges each one with wvalid_mem. It is backed by an internal line-beat array and sits between the refill/write-back engines and the memory model in simulation and FPGA builds.

## Interface
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 64, half-beat width; beat = 2*DATA_WIDTH bits.
- DEPTH, 256, number of beats stored; power of two, >= 2.
- LATENCY, 2, wait cycles between request acceptance and response; >= 1.

- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- ren_mem  in  1  read request; held high by the requester until served or abandoned.
- raddr_mem  in  ADDR_WIDTH  read byte address.
- rvalid_mem  out  1  one-cycle read response strobe.
- rdata_mem  out  2*DATA_WIDTH  read data; valid while rvalid_mem=1.
- wen_mem  in  1  write request; held high until acknowledged.
- waddr_mem  in  ADDR_WIDTH  write byte address.
- wdata_mem  in  2*DATA_WIDTH  write data.
- wmask_mem  in  2*DATA_WIDTH/8  byte enables; bit i enables byte i.
- wvalid_mem  out  1  one-cycle write acknowledge.

## Operation
- Index = addr[4 +: log2(DEPTH)]. Bits [3:0] are ignored and upper bits wrap, so out-of-range addresses alias.
- FSM states:
  - IDLE: no transaction in progress.
  - RBUSY / WBUSY: latency countdown.
  - RRESP / WRESP: response cycle.
  - GAP: one dead cycle after every response.
- IDLE transitions:
  - ren_mem=1: latch the index, set cnt=0, go to RBUSY.
  - Otherwise, if wen_mem=1: latch index, data and mask, then go to WBUSY.
  - Read wins when both requests are high. The write stays pending because its requester holds wen_mem.
- RBUSY:
  - If ren_mem=0, abandon: go to IDLE with no response.
  - Otherwise cnt++. When cnt==LATENCY-1, register rdata_mem=mem[index] and rvalid_mem=1, then go to RRESP.
- WBUSY:
  - Same countdown, but no abandon. Once accepted, a write always completes.
  - On the final count, update mem[index] with masked byte writes and set wvalid_mem=1, then go to WRESP.
- RRESP / WRESP: clear rvalid_mem/wvalid_mem and go to GAP.
- GAP: go to IDLE, with no request sampling.
  - The requester updates its address on the same edge where it sees the strobe.
  - GAP guarantees the next acceptance in IDLE sees the new address.
- rdata_mem holds its last value outside RRESP.
- Storage is not reset. Contents survive rstn.

## Timing
- Reset values:
  - rvalid_mem=0, wvalid_mem=0, rdata_mem=0.
  - state=IDLE, cnt=0, latched index/data/mask=0.
- Request accepted at edge E0, with state IDLE and request high.
- The response strobe is high during the cycle after edge E0+LATENCY, for exactly one cycle.
- Beat period for back-to-back requests is LATENCY+3 cycles from acceptance to next acceptance.
- A write is visible to a read accepted at any edge after the write's wvalid_mem edge.
- An async reset mid-transaction forces IDLE and drops the strobes immediately. If wvalid_mem has not yet been raised, the pending write is not performed.
- If ren_mem drops during RRESP or GAP, there is no effect; the response has already been issued.
- A read and write to the same index with the write accepted first: the read returns the new data.

## Test plan
- Reset, then write 0x0011_2233_4455_6677_8899_AABB_CCDD_EEFF to 0x40 with full mask, then read 0x40.
  - wvalid_mem pulses once, 3 cycles after acceptance.
  - rvalid_mem pulses with identical data; no other strobes.
- Masked write wmask=0x000F of 0x...DEADBEEF over an existing all-0x11 beat at 0x80, then read.
  - Result is 0x1111...1111DEADBEEF.
- Refill burst:
  - Requester asserts ren at 0x100 and advances raddr by 16 on each rvalid, for 3 beats.
  - Required: three rvalid pulses, LATENCY+3 cycles apart, returning beats 0x100/0x110/0x120; no duplicated beat.
- ren_mem and wen_mem rise together.
  - Read is served first; the write is acknowledged afterwards.
  - A second read of the write address returns the written data.
- Abandon: drop ren_mem one cycle after acceptance.
  - No rvalid_mem; the FSM returns to IDLE and serves the next request normally.
- Assert rstn=0 during WBUSY.
  - Strobes are 0 immediately and the array location is unchanged.
  - After reset, a read returns the old data.
- Alias check: write address DEPTH*16+0x20, read 0x20 -> same data.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency, one-at-a-time single-beat read/write responder
// backed by a beat array; every response is followed by one dead cycle.
module mem_responder #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      ren_mem,
    input  logic [ADDR_WIDTH-1:0]     raddr_mem,
    output logic                      rvalid_mem,
    output logic [2*DATA_WIDTH-1:0]   rdata_mem,
    input  logic                      wen_mem,
    input  logic [ADDR_WIDTH-1:0]     waddr_mem,
    input  logic [2*DATA_WIDTH-1:0]   wdata_mem,
    input  logic [2*DATA_WIDTH/8-1:0] wmask_mem,
    output logic                      wvalid_mem
);
    localparam int BW = 2 * DATA_WIDTH;
    localparam int MW = BW / 8;
    localparam int IW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RBUSY = 3'd1,
        WBUSY = 3'd2,
        RRESP = 3'd3,
        WRESP = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [BW-1:0] wbeat, wbeat_nx;
    logic [MW-1:0] wmask, wmask_nx;
    logic          rvalid_nx, wvalid_nx;
    logic [BW-1:0] rdata_nx;
    logic          mem_we;
    logic [BW-1:0] mem [DEPTH];

    // Offset bits and wrapped upper bits are intentionally ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{raddr_mem[3:0], raddr_mem[ADDR_WIDTH-1:4+IW],
                                waddr_mem[3:0], waddr_mem[ADDR_WIDTH-1:4+IW]};

    function automatic logic [BW-1:0] merge_bytes(input logic [BW-1:0] old_beat,
                                                  input logic [BW-1:0] new_beat,
                                                  input logic [MW-1:0] mask);
        logic [BW-1:0] res;
        res = old_beat;
        for (int b = 0; b < MW; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_beat[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_beat[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // Next-state, countdown and response generation
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        wbeat_nx  = wbeat;
        wmask_nx  = wmask;
        rvalid_nx = rvalid_mem;
        wvalid_nx = wvalid_mem;
        rdata_nx  = rdata_mem;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (ren_mem) begin
                    idx_nx   = raddr_mem[4 +: IW];
                    cnt_nx   = {CW{1'b0}};
                    state_nx = RBUSY;
                end else if (wen_mem) begin
                    idx_nx   = waddr_mem[4 +: IW];
                    wbeat_nx = wdata_mem;
                    wmask_nx = wmask_mem;
                    cnt_nx   = {CW{1'b0}};
                    state_nx = WBUSY;
                end else begin
                    state_nx = IDLE;
                end
            end
            RBUSY: begin
                if (!ren_mem) begin
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    rdata_nx  = mem[idx];
                    rvalid_nx = 1'b1;
                    state_nx  = RRESP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            WBUSY: begin
                // No abandon path: an accepted write always lands.
                if (cnt == CNT_LAST) begin
                    mem_we    = 1'b1;
                    wvalid_nx = 1'b1;
                    state_nx  = WRESP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            RRESP: begin
                rvalid_nx = 1'b0;
                state_nx  = GAP;
            end
            WRESP: begin
                wvalid_nx = 1'b0;
                state_nx  = GAP;
            end
            GAP: begin
                state_nx = IDLE;
            end
            default: begin
                rvalid_nx = 1'b0;
                wvalid_nx = 1'b0;
                state_nx  = IDLE;
            end
        endcase
    end

    // Control state, transaction latches and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= {CW{1'b0}};
            idx        <= {IW{1'b0}};
            wbeat      <= {BW{1'b0}};
            wmask      <= {MW{1'b0}};
            rvalid_mem <= 1'b0;
            wvalid_mem <= 1'b0;
            rdata_mem  <= {BW{1'b0}};
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            wbeat      <= wbeat_nx;
            wmask      <= wmask_nx;
            rvalid_mem <= rvalid_nx;
            wvalid_mem <= wvalid_nx;
            rdata_mem  <= rdata_nx;
        end
    end

    // Beat array has no reset so its contents survive rstn
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= merge_bytes(mem[idx], wbeat, wmask);
        end
    end
endmodule
